// File: rtl/pu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pu_pkg : shared widths, FSM state encoding and helpers for pu_seq  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pu_pkg;

  localparam int DEF_PC_W = 8;
  localparam int DEF_IW   = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4
  } pu_state_e;

  // Retired-instruction counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pu_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pu_seq_if : fetch bus, decoder hand-off and status of the sequencer|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface pu_seq_if #(
  parameter int PC_W = pu_pkg::DEF_PC_W,
  parameter int IW   = pu_pkg::DEF_IW
);

  logic            run;
  logic [PC_W-1:0] imem_addr;
  logic            imem_req;
  logic            imem_ack;
  logic [IW-1:0]   imem_rdata;
  logic [IW-1:0]   ir;
  logic            dec_we;
  logic            dec_halt;
  logic            dec_ll;
  logic            dec_lh;
  logic            rf_we;
  logic            ld_lo;
  logic            ld_hi;
  logic            halted;
  logic [15:0]     instret;
  logic [2:0]      state;

  modport master (
    input  run, imem_ack, imem_rdata, dec_we, dec_halt, dec_ll, dec_lh,
    output imem_addr, imem_req, ir, rf_we, ld_lo, ld_hi, halted, instret, state
  );

  modport slave (
    output run, imem_ack, imem_rdata, dec_we, dec_halt, dec_ll, dec_lh,
    input  imem_addr, imem_req, ir, rf_we, ld_lo, ld_hi, halted, instret, state
  );

endinterface
`default_nettype wire

// File: rtl/pu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pu_seq : fetch / execute / write-back sequencer of a tiny core     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pu_seq
  import pu_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int IW   = DEF_IW
) (
  input  logic      clk,
  input  logic      rst_n,
  pu_seq_if.master  bus
);

  pu_state_e       state_q,   state_d;
  logic [PC_W-1:0] pc_q,      pc_d;
  logic [IW-1:0]   ir_q,      ir_d;
  logic [15:0]     instret_q, instret_d;

  logic            any_wr;
  logic            wb_live;

  assign any_wr = bus.dec_we | bus.dec_ll | bus.dec_lh;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    instret_d = instret_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (bus.dec_halt) begin
          instret_d = sat_inc16(instret_q);
          state_d   = ST_HALT;
        end else if (any_wr) begin
          state_d = ST_WB;
        end else begin
          pc_d      = pc_q + PC_W'(1);
          instret_d = sat_inc16(instret_q);
          state_d   = ST_FETCH;
        end
      end
      ST_WB: begin
        pc_d      = pc_q + PC_W'(1);
        instret_d = sat_inc16(instret_q);
        state_d   = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
    end
  end

  // Strobes are gated by rst_n so a reset landing in WB commits nothing.
  assign wb_live = (state_q == ST_WB) && rst_n;

  assign bus.imem_addr = pc_q;
  assign bus.imem_req  = (state_q == ST_FETCH);
  assign bus.ir        = ir_q;
  assign bus.rf_we     = wb_live && bus.dec_we;
  assign bus.ld_lo     = wb_live && bus.dec_ll;
  assign bus.ld_hi     = wb_live && bus.dec_lh;
  assign bus.halted    = (state_q == ST_HALT);
  assign bus.instret   = instret_q;
  assign bus.state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pu_seq : directed vector bench for pu_seq                       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pu_seq;

  logic clk;
  logic rst_n;

  pu_seq_if #(.PC_W(8), .IW(16)) bus ();

  pu_seq #(.PC_W(8), .IW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with programmable ack latency, measured from the first req cycle.
  logic [15:0] mem [256];
  int          ack_delay;
  int          wait_cnt;

  assign bus.imem_rdata = mem[bus.imem_addr];
  assign bus.imem_ack   = bus.imem_req && (wait_cnt >= ack_delay);

  always @(posedge clk) begin
    if (bus.imem_req && !bus.imem_ack) wait_cnt <= wait_cnt + 1;
    else                               wait_cnt <= 0;
  end

  // Decoder model: ir[15]=halt, ir[14]=lh, ir[13]=ll, ir[12]=we.
  assign bus.dec_halt = bus.ir[15];
  assign bus.dec_lh   = bus.ir[14];
  assign bus.dec_ll   = bus.ir[13];
  assign bus.dec_we   = bus.ir[12];

  int n_vec;
  int n_err;

  typedef struct {
    logic [15:0] i0;
    logic [15:0] i1;
    int          we;
    int          ll;
    int          lh;
    int          pc;
    int          ret;
    int          cyc;
  } vec_t;

  vec_t tbl [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fill_mem(input logic [15:0] v);
    for (int a = 0; a < 256; a++) mem[a] = v;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.run = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc, cwe, cll, clh;
    logic ok;

    n_vec     = 0;
    n_err     = 0;
    ack_delay = 0;
    rst_n     = 1'b0;
    bus.run   = 1'b0;
    fill_mem(16'h8000);

    //          i0        i1        we ll lh pc ret cyc
    tbl[0] = '{16'h1000, 16'h0000, 1, 0, 0, 2, 3, 8};
    tbl[1] = '{16'h0000, 16'h8000, 0, 0, 0, 1, 2, 5};
    tbl[2] = '{16'h2000, 16'h4000, 0, 1, 1, 2, 3, 9};
    tbl[3] = '{16'h7000, 16'h0000, 1, 1, 1, 2, 3, 8};
    tbl[4] = '{16'h9000, 16'h1000, 0, 0, 0, 0, 1, 3};
    tbl[5] = '{16'h0000, 16'h0000, 0, 0, 0, 2, 3, 7};

    // Reset state
    do_reset();
    chk("rst_state",   bus.state,    0);
    chk("rst_pc",      bus.imem_addr, 0);
    chk("rst_ir",      bus.ir,       0);
    chk("rst_instret", bus.instret,  0);
    chk("rst_halted",  bus.halted,   0);
    chk("rst_req",     bus.imem_req, 0);
    chk("rst_strobes", {bus.rf_we, bus.ld_lo, bus.ld_hi}, 0);
    step();
    chk("idle_hold",   bus.state,    0);

    // Two-instruction programs followed by halt
    for (int v = 0; v < 6; v++) begin
      fill_mem(16'h8000);
      mem[0] = tbl[v].i0;
      mem[1] = tbl[v].i1;
      do_reset();
      bus.run = 1'b1;
      cyc = 0; cwe = 0; cll = 0; clh = 0;
      for (int k = 0; k < 100; k++) begin
        step();
        cyc++;
        cwe += int'(bus.rf_we);
        cll += int'(bus.ld_lo);
        clh += int'(bus.ld_hi);
        if (bus.halted) break;
      end
      chk($sformatf("v%0d_halted", v),  bus.halted,    1);
      chk($sformatf("v%0d_cycles", v),  cyc,           tbl[v].cyc);
      chk($sformatf("v%0d_rf_we", v),   cwe,           tbl[v].we);
      chk($sformatf("v%0d_ld_lo", v),   cll,           tbl[v].ll);
      chk($sformatf("v%0d_ld_hi", v),   clh,           tbl[v].lh);
      chk($sformatf("v%0d_pc", v),      bus.imem_addr, tbl[v].pc);
      chk($sformatf("v%0d_instret", v), bus.instret,   tbl[v].ret);
    end

    // Write instruction: strobe timing relative to run
    fill_mem(16'h8000);
    mem[0] = 16'h1001;
    do_reset();
    bus.run = 1'b1;
    step();
    chk("w_fetch_state", bus.state,    1);
    chk("w_fetch_req",   bus.imem_req, 1);
    step();
    chk("w_exec_state",  bus.state,    2);
    chk("w_exec_rf_we",  bus.rf_we,    0);
    step();
    chk("w_wb_rf_we",    bus.rf_we,    1);
    chk("w_wb_req",      bus.imem_req, 0);
    step();
    chk("w_post_rf_we",  bus.rf_we,    0);
    chk("w_post_pc",     bus.imem_addr, 1);
    chk("w_post_ret",    bus.instret,  1);

    // Halt is sticky with run held high
    fill_mem(16'h8000);
    mem[0] = 16'h0000;
    do_reset();
    bus.run = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      if (bus.halted) break;
    end
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!bus.halted || bus.state != 3'd4 || bus.imem_addr != 8'd1 ||
          bus.imem_req || bus.rf_we || bus.ld_lo || bus.ld_hi) ok = 1'b0;
    end
    chk("halt_sticky",  ok,          1);
    chk("halt_instret", bus.instret, 2);

    // Delayed ack: address held, ir loads only on the ack cycle
    fill_mem(16'h8000);
    mem[0]    = 16'h1ABC;
    ack_delay = 4;
    do_reset();
    bus.run = 1'b1;
    step();
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (!bus.imem_req || bus.imem_ack || bus.imem_addr != 8'd0 || bus.ir != 16'h0) ok = 1'b0;
      step();
    end
    chk("dly_wait_stable", ok,           1);
    chk("dly_ack_cycle",   bus.imem_ack, 1);
    chk("dly_ack_ir_old",  bus.ir,       16'h0000);
    step();
    chk("dly_ir_loaded",   bus.ir,       16'h1ABC);
    chk("dly_exec_state",  bus.state,    2);
    ack_delay = 0;

    // PC wrap after 256 nops
    fill_mem(16'h0000);
    do_reset();
    bus.run = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      step();
      if (bus.state == 3'd1 && bus.imem_addr == 8'hFF) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wrap_reach_ff", ok, 1);
    step();
    step();
    chk("wrap_state",   bus.state,     1);
    chk("wrap_addr",    bus.imem_addr, 0);
    chk("wrap_instret", bus.instret,   256);

    // Reset asserted during WB
    fill_mem(16'h8000);
    mem[0] = 16'h1000;
    do_reset();
    bus.run = 1'b1;
    step();
    step();
    step();
    chk("wbrst_pre_rf_we", bus.rf_we, 1);
    rst_n = 1'b0;
    #1;
    chk("wbrst_rf_we",   bus.rf_we,     0);
    step();
    chk("wbrst_state",   bus.state,     0);
    chk("wbrst_pc",      bus.imem_addr, 0);
    chk("wbrst_instret", bus.instret,   0);
    chk("wbrst_ir",      bus.ir,        0);
    rst_n = 1'b1;

    // Reset asserted mid-FETCH with ack high
    do_reset();
    bus.run = 1'b1;
    step();
    chk("frst_ack", bus.imem_ack, 1);
    rst_n = 1'b0;
    step();
    chk("frst_state", bus.state, 0);
    chk("frst_ir",    bus.ir,    0);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pu_seq.md
PU_SEQ -- requirements
Module: pu_seq

Interface
REQ-001 SHALL: parameter PC_W, default 8, program-counter and instruction-address width.
REQ-002 SHALL: parameter IW, default 16, instruction width.
REQ-003 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL: rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL: run  in  1  level; leaves IDLE when sampled high.
REQ-006 SHALL: imem_addr  out  PC_W  fetch address, equal to the PC.
REQ-007 SHALL: imem_req  out  1  fetch request.
REQ-008 SHALL: imem_ack  in  1  imem_rdata valid this cycle; ignored unless imem_req=1.
REQ-009 SHALL: imem_rdata  in  IW  fetched instruction.
REQ-010 SHALL: ir  out  IW  instruction register; drives the decoder input.
REQ-011 SHALL: dec_we, dec_halt, dec_ll, dec_lh  in  1 each  decoder outputs for ir.
REQ-012 SHALL: rf_we, ld_lo, ld_hi  out  1 each  one-cycle commit strobes to the register file.
REQ-013 SHALL: halted  out  1  core stopped.
REQ-014 SHALL: instret  out  16  retired-instruction count.
REQ-015 SHALL: state  out  3  FSM state encoding, debug only.

Function
REQ-016 SHALL: implement FSM states IDLE, FETCH, EXEC, WB, HALT.
REQ-017 SHALL: stay in IDLE while run=0, and go to FETCH on run=1.
REQ-018 SHALL: in FETCH, assert imem_req=1 and hold imem_addr stable until imem_ack, with no timeout; zero-wait ack gives fetch latency of 1 cycle.
REQ-019 SHALL: on FETCH with imem_ack=1, load ir from imem_rdata and go to EXEC.
REQ-020 SHALL: in EXEC, with decoder inputs sampled combinationally from ir:
- dec_halt=1 -> HALT; dec_halt has priority over all other decoder inputs.
- else any of dec_we/dec_ll/dec_lh =1 -> WB.
- else (nop) -> increment PC, increment instret, then FETCH.
REQ-021 SHALL: in WB, assert rf_we=dec_we, ld_lo=dec_ll, ld_hi=dec_lh for exactly one cycle, increment PC and instret, then go to FETCH.
REQ-022 SHALL: drive rf_we, ld_lo and ld_hi to 0 in every state other than WB.
REQ-023 SHALL: drive imem_req to 0 in every state other than FETCH.
REQ-024 SHALL: wrap PC modulo 2^PC_W, so 8'hFF+1 -> 8'h00 with no flag.
REQ-025 SHALL: saturate instret at 16'hFFFF.
REQ-026 SHALL: count a halt instruction in instret once on entry to HALT; leave PC unchanged on halt.
REQ-027 SHALL: keep HALT sticky with halted=1, and leave it only via reset; run is ignored in HALT.
REQ-028 SHALL: keep ir unchanged outside FETCH-with-ack.
REQ-029 SHALL: give a non-halting instruction with zero-wait memory a cost of 3 cycles if it writes (FETCH, EXEC, WB) and 2 cycles if it is a nop.

Reset
REQ-030 SHALL: on rst_n=0 at a clock edge, set state=IDLE, PC=0, ir=0, instret=0, halted=0 and all strobes 0.
REQ-031 SHALL: give reset priority over every transition, including mid-FETCH with ack high and in WB, where the strobe is suppressed in the reset cycle.

Structure
REQ-032 SHALL: place the state enum, PC_W and IW defaults in shared package pu_pkg.
REQ-033 SHALL: contain no sub-module; dec is instantiated beside pu_seq by the parent, with ir feeding it.

Verification
REQ-034 SHALL: run=1, zero-wait memory, mem[0]=ALU write r1 -> rf_we high for exactly 1 cycle, 3 cycles after run; PC=1; instret=1.
REQ-035 SHALL: mem[0]=nop, mem[1]=halt -> no strobes; PC=1 at halt; halted=1 sticky for 20 cycles with run=1; instret=2.
REQ-036 SHALL: imem_ack delayed 4 cycles -> imem_req=1 with imem_addr constant for 4 cycles; ir loads only on the ack cycle.
REQ-037 SHALL: PC preloaded to 8'hFF by running nops -> next fetch address 8'h00.
REQ-038 SHALL: rst_n=0 in the WB cycle -> rf_we=0, state=IDLE and PC=0 on the next cycle.
REQ-039 SHALL: EXEC with dec_halt=1 and dec_we=1 -> HALT entered and rf_we never asserted.
